// File: rtl/rca_selftest_reconfig_ctrl_if.sv
// Signal bundle between the self-test/reconfiguration controller and its
// surroundings: checker pattern/clear handshake, spare-slice mapping and status.
interface rca_selftest_reconfig_ctrl_if #(
    parameter int NSLICE = 4,
    parameter int PW     = 3
);
    logic              start;
    logic [NSLICE-1:0] fault_cs;
    logic [PW-1:0]     pat_idx;
    logic              pat_valid;
    logic              chk_clr;
    logic [NSLICE-1:0] sel_spare;
    logic [NSLICE-1:0] fault_map;
    logic              swap_evt;
    logic              busy;
    logic              pass;
    logic              fail;

    modport master (
        input  start, fault_cs,
        output pat_idx, pat_valid, chk_clr, sel_spare, fault_map,
               swap_evt, busy, pass, fail
    );

    modport slave (
        output start, fault_cs,
        input  pat_idx, pat_valid, chk_clr, sel_spare, fault_map,
               swap_evt, busy, pass, fail
    );
endinterface

// File: rtl/rca_selftest_reconfig_ctrl.sv
// Self-test epoch sequencer for the ripple-carry adder: walks the checker
// patterns, evaluates sticky slice faults and remaps one faulty slice to the spare.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start after reset
// CLEAR | one-cycle clear request to the checker's sticky register
// APPLY | pat_idx walks 0..NPAT-1, pat_valid high
// WAIT  | SETTLE cycles for checker register latency
// EVAL  | sample fault_cs, accumulate fault_map, decide outcome
// SWAP  | commit single-slice remap, then re-run epoch to verify
// PASS  | epoch clean; start re-tests with mapping retained
// FAIL  | terminal until reset
module rca_selftest_reconfig_ctrl #(
    parameter int NSLICE = 4,
    parameter int PW     = 3,
    parameter int SETTLE = 2
) (
    input  logic                          clk,
    input  logic                          clr,
    rca_selftest_reconfig_ctrl_if.master  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] APPLY = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] EVAL  = 3'd4;
    localparam logic [2:0] SWAP  = 3'd5;
    localparam logic [2:0] PASS  = 3'd6;
    localparam logic [2:0] FAIL  = 3'd7;

    localparam logic [PW-1:0] PAT_LAST  = {PW{1'b1}};
    localparam logic [3:0]    SETTLE_LD = 4'(SETTLE - 1);

    logic [2:0]        state, state_nxt;
    logic [PW-1:0]     pat_cnt, pat_nxt;
    logic [3:0]        settle_cnt, settle_nxt;
    logic              spare_used;
    logic [NSLICE-1:0] sel_spare_q;
    logic [NSLICE-1:0] fault_map_q;
    logic              pat_valid_q;
    logic              chk_clr_q;
    logic              swap_evt_q;
    logic              busy_q;
    logic              pass_q;
    logic              fail_q;
    logic              single_fault;

    assign single_fault = $onehot(bus.fault_cs);

    always_comb begin
        state_nxt  = state;
        pat_nxt    = pat_cnt;
        settle_nxt = settle_cnt;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = CLEAR;
            end
            CLEAR: begin
                state_nxt = APPLY;
                pat_nxt   = '0;
            end
            APPLY: begin
                if (pat_cnt == PAT_LAST) begin
                    state_nxt  = WAIT;
                    pat_nxt    = '0;
                    settle_nxt = SETTLE_LD;
                end else begin
                    pat_nxt = pat_cnt + PW'(1);
                end
            end
            WAIT: begin
                if (settle_cnt == 4'd0) state_nxt = EVAL;
                else                    settle_nxt = settle_cnt - 4'd1;
            end
            EVAL: begin
                if (bus.fault_cs == '0)               state_nxt = PASS;
                else if (single_fault && !spare_used) state_nxt = SWAP;
                else                                  state_nxt = FAIL;
            end
            SWAP: begin
                state_nxt = CLEAR;
            end
            PASS: begin
                if (bus.start) state_nxt = CLEAR;
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every flag is a flop.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= IDLE;
            pat_cnt     <= '0;
            settle_cnt  <= 4'd0;
            spare_used  <= 1'b0;
            sel_spare_q <= '0;
            fault_map_q <= '0;
            pat_valid_q <= 1'b0;
            chk_clr_q   <= 1'b0;
            swap_evt_q  <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pat_cnt     <= pat_nxt;
            settle_cnt  <= settle_nxt;
            pat_valid_q <= (state_nxt == APPLY);
            chk_clr_q   <= (state_nxt == CLEAR);
            swap_evt_q  <= (state_nxt == SWAP);
            pass_q      <= (state_nxt == PASS);
            fail_q      <= (state_nxt == FAIL);
            busy_q      <= (state_nxt != IDLE) && (state_nxt != PASS) &&
                           (state_nxt != FAIL);
            if (state == EVAL) begin
                fault_map_q <= fault_map_q | bus.fault_cs;
            end
            // The spare is committed once; SWAP is unreachable afterwards.
            if ((state == EVAL) && (state_nxt == SWAP)) begin
                sel_spare_q <= bus.fault_cs;
                spare_used  <= 1'b1;
            end
        end
    end

    assign bus.pat_idx   = pat_cnt;
    assign bus.pat_valid = pat_valid_q;
    assign bus.chk_clr   = chk_clr_q;
    assign bus.sel_spare = sel_spare_q;
    assign bus.fault_map = fault_map_q;
    assign bus.swap_evt  = swap_evt_q;
    assign bus.busy      = busy_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
endmodule

// File: tb/tb_rca_selftest_reconfig_ctrl.sv
// Scoreboard bench for rca_selftest_reconfig_ctrl: expected per-cycle outputs
// are queued with their stimulus and compared one cycle at a time.
module tb_rca_selftest_reconfig_ctrl;
    logic clk;
    logic clr;

    rca_selftest_reconfig_ctrl_if #(.NSLICE(4), .PW(3)) bus ();

    rca_selftest_reconfig_ctrl #(.NSLICE(4), .PW(3), .SETTLE(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] pat;
        logic       valid;
        logic       cclr;
        logic [3:0] sel;
        logic [3:0] map;
        logic       swp;
        logic       busy;
        logic       pass;
        logic       fail;
    } out_t;

    typedef struct packed {
        logic       st;
        logic [3:0] flt;
    } stim_t;

    out_t  exp_q[$];
    stim_t stim_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    vidx;
    out_t  obs, e;
    stim_t s;

    function automatic out_t sample();
        out_t o;
        o.pat   = bus.pat_idx;
        o.valid = bus.pat_valid;
        o.cclr  = bus.chk_clr;
        o.sel   = bus.sel_spare;
        o.map   = bus.fault_map;
        o.swp   = bus.swap_evt;
        o.busy  = bus.busy;
        o.pass  = bus.pass;
        o.fail  = bus.fail;
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("pat=%0d val=%b clr=%b sel=%b map=%b swp=%b busy=%b pass=%b fail=%b",
                         o.pat, o.valid, o.cclr, o.sel, o.map, o.swp, o.busy, o.pass, o.fail);
    endfunction

    function automatic out_t mk(input logic [2:0] pat, input logic valid, input logic cclr,
                                input logic [3:0] sel, input logic [3:0] map, input logic swp,
                                input logic busy, input logic pass, input logic fail);
        out_t o;
        o.pat = pat; o.valid = valid; o.cclr = cclr; o.sel = sel; o.map = map;
        o.swp = swp; o.busy = busy; o.pass = pass; o.fail = fail;
        return o;
    endfunction

    task automatic push(input out_t o, input logic st, input logic [3:0] flt);
        stim_t t;
        t.st  = st;
        t.flt = flt;
        exp_q.push_back(o);
        stim_q.push_back(t);
    endtask

    // CLEAR, 8x APPLY, 2x WAIT, EVAL. f_eval is driven only during EVAL;
    // noise is driven on fault_cs in every other cycle and must be ignored.
    task automatic push_epoch(input logic [3:0] sel, input logic [3:0] map,
                              input logic [3:0] f_eval, input logic [3:0] noise,
                              input logic st);
        push(mk(3'd0, 1'b0, 1'b1, sel, map, 1'b0, 1'b1, 1'b0, 1'b0), st, noise);
        for (int k = 0; k < 8; k++)
            push(mk(3'(k), 1'b1, 1'b0, sel, map, 1'b0, 1'b1, 1'b0, 1'b0), st, noise);
        for (int k = 0; k < 2; k++)
            push(mk(3'd0, 1'b0, 1'b0, sel, map, 1'b0, 1'b1, 1'b0, 1'b0), st, noise);
        push(mk(3'd0, 1'b0, 1'b0, sel, map, 1'b0, 1'b1, 1'b0, 1'b0), st, f_eval);
    endtask

    task automatic apply_reset();
        clr = 1'b0;
        bus.start = 1'b0;
        bus.fault_cs = 4'b0000;
        @(posedge clk);
        #1;
        clr = 1'b1;
        exp_q.delete();
        stim_q.delete();
        vidx = 0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        bus.start = 1'b1;
        bus.fault_cs = 4'b1111;
        #3;
        vectors++;
        obs = sample();
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_async got %s want all zero", fmt(obs));
        end
        @(posedge clk);
        #1;
        vectors++;
        obs = sample();
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_held got %s want all zero", fmt(obs));
        end
        apply_reset();
    endtask

    task automatic test_pass();
        apply_reset();
        bus.start = 1'b1;
        push_epoch(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        for (int k = 0; k < 3; k++)
            push(mk(3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, 4'b0000);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            obs = sample();
            e = exp_q.pop_front();
            s = stim_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL pass v%0d got %s want %s", vidx, fmt(obs), fmt(e));
            end
            vidx++;
            bus.start = s.st;
            bus.fault_cs = s.flt;
        end
    endtask

    task automatic test_swap_pass();
        apply_reset();
        bus.start = 1'b1;
        push_epoch(4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0);
        push(mk(3'd0, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 4'b0000);
        push_epoch(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0);
        push(mk(3'd0, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, 4'b0000);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            obs = sample();
            e = exp_q.pop_front();
            s = stim_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL swap_pass v%0d got %s want %s", vidx, fmt(obs), fmt(e));
            end
            vidx++;
            bus.start = s.st;
            bus.fault_cs = s.flt;
        end
    endtask

    task automatic test_swap_fail();
        apply_reset();
        bus.start = 1'b1;
        push_epoch(4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0);
        push(mk(3'd0, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 4'b0100);
        push_epoch(4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b0);
        for (int k = 0; k < 4; k++)
            push(mk(3'd0, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 4'b0000);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            obs = sample();
            e = exp_q.pop_front();
            s = stim_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL swap_fail v%0d got %s want %s", vidx, fmt(obs), fmt(e));
            end
            vidx++;
            bus.start = s.st;
            bus.fault_cs = s.flt;
        end
    endtask

    task automatic test_double_fault();
        apply_reset();
        bus.start = 1'b1;
        push_epoch(4'b0000, 4'b0000, 4'b0011, 4'b0000, 1'b0);
        for (int k = 0; k < 2; k++)
            push(mk(3'd0, 1'b0, 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 4'b0000);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            obs = sample();
            e = exp_q.pop_front();
            s = stim_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL double_fault v%0d got %s want %s", vidx, fmt(obs), fmt(e));
            end
            vidx++;
            bus.start = s.st;
            bus.fault_cs = s.flt;
        end
    endtask

    task automatic test_spare_used();
        apply_reset();
        bus.start = 1'b1;
        push_epoch(4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0);
        push(mk(3'd0, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 4'b1111);
        push_epoch(4'b0010, 4'b0010, 4'b0000, 4'b1111, 1'b0);
        push(mk(3'd0, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, 4'b0000);
        push_epoch(4'b0010, 4'b0010, 4'b1000, 4'b0000, 1'b0);
        push(mk(3'd0, 1'b0, 1'b0, 4'b0010, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, 4'b0000);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            obs = sample();
            e = exp_q.pop_front();
            s = stim_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL spare_used v%0d got %s want %s", vidx, fmt(obs), fmt(e));
            end
            vidx++;
            bus.start = s.st;
            bus.fault_cs = s.flt;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.start = 1'b1;
        push(mk(3'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 4'b0000);
        for (int k = 0; k < 6; k++)
            push(mk(3'(k), 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 4'b0000);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            obs = sample();
            e = exp_q.pop_front();
            s = stim_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset_mid_pre v%0d got %s want %s", vidx, fmt(obs), fmt(e));
            end
            vidx++;
            bus.start = s.st;
            bus.fault_cs = s.flt;
        end
        #2;
        clr = 1'b0;
        #1;
        vectors++;
        obs = sample();
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_async got %s want all zero", fmt(obs));
        end
        @(posedge clk);
        #1;
        clr = 1'b1;
        bus.start = 1'b1;
        vidx = 0;
        push_epoch(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        push(mk(3'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, 4'b0000);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            obs = sample();
            e = exp_q.pop_front();
            s = stim_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset_mid_post v%0d got %s want %s", vidx, fmt(obs), fmt(e));
            end
            vidx++;
            bus.start = s.st;
            bus.fault_cs = s.flt;
        end
    endtask

    initial begin
        clr = 1'b0;
        bus.start = 1'b0;
        bus.fault_cs = 4'b0000;
        vidx = 0;
        test_reset();
        test_pass();
        test_swap_pass();
        test_swap_fail();
        test_double_fault();
        test_spare_used();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors", vectors);
        $fatal(1, "watchdog");
    end
endmodule
